// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the packet round-robin FIFO arbiter.
//   arb_state_e : arbiter FSM state (IDLE = free to arbitrate, LOCKED = mid-packet)
//   rr_next     : (idx + 1) mod n, valid for any n >= 1 (not only powers of two)
package fifo_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Combinational rotate-priority encoder.
//   req       : request vector, bit i = requester i wants service
//   rr_ptr    : index with highest priority; priority falls off rr_ptr+1, ... mod P_NUM_REQ
//   sel       : chosen index (0 when nothing is requested)
//   sel_valid : at least one request bit is set
module fifo_arb_rr_pick #(
  parameter int P_NUM_REQ   = 4,
  parameter int P_IDX_WIDTH = $clog2(P_NUM_REQ)
) (
  input  logic [P_NUM_REQ-1:0]   req,
  input  logic [P_IDX_WIDTH-1:0] rr_ptr,
  output logic [P_IDX_WIDTH-1:0] sel,
  output logic                   sel_valid
);

  // rr_ptr is always < P_NUM_REQ, so one conditional subtract is a full modulo.
  function automatic int wrap_add(input int base, input int off);
    return (base + off >= P_NUM_REQ) ? base + off - P_NUM_REQ : base + off;
  endfunction

  // Scan from the farthest offset down to rr_ptr itself so the closest
  // requester (smallest offset) is the last writer and therefore wins.
  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    for (int k = P_NUM_REQ - 1; k >= 0; k--) begin
      if (req[wrap_add(int'(rr_ptr), k)]) begin
        sel       = P_IDX_WIDTH'(wrap_add(int'(rr_ptr), k));
        sel_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Packet-level round-robin arbiter between P_NUM_REQ FWFT FIFOs and one consumer.
// Whole packets (terminated by req_last) are forwarded without interleaving.
//   clk, rst     : clock, synchronous active-high reset
//   req_empty    : per-FIFO empty flag; head word valid when low
//   req_data     : per-FIFO head data
//   req_last     : per-FIFO head word ends a packet
//   req_rd_en    : per-FIFO pop strobe (combinational, at most one bit high)
//   out_valid/out_data/out_last/out_src : registered output word and its source
//   out_ready    : consumer accepts the word
//   dbg_state, dbg_rr_ptr, dbg_lock_idx : internal FSM state for observation
//
// Handshake: a word transfers on a rising edge where out_valid && out_ready.
// While out_valid && !out_ready all out_* hold and nothing is popped. The output
// register accepts a new word whenever it is empty or being drained that cycle,
// so back-to-back words flow at one per cycle.
module fifo_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int P_NUM_REQ    = 4,
  parameter int P_DATA_WIDTH = 32,
  parameter int P_IDX_WIDTH  = $clog2(P_NUM_REQ)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [P_NUM_REQ-1:0]                  req_empty,
  input  logic [P_NUM_REQ-1:0][P_DATA_WIDTH-1:0] req_data,
  input  logic [P_NUM_REQ-1:0]                  req_last,
  output logic [P_NUM_REQ-1:0]                  req_rd_en,
  output logic                                  out_valid,
  output logic [P_DATA_WIDTH-1:0]               out_data,
  output logic                                  out_last,
  output logic [P_IDX_WIDTH-1:0]                out_src,
  input  logic                                  out_ready,
  output arb_state_e                            dbg_state,
  output logic [P_IDX_WIDTH-1:0]                dbg_rr_ptr,
  output logic [P_IDX_WIDTH-1:0]                dbg_lock_idx
);

  arb_state_e             state;
  logic [P_IDX_WIDTH-1:0] rr_ptr;
  logic [P_IDX_WIDTH-1:0] lock_idx;

  logic [P_IDX_WIDTH-1:0] pick_sel;
  logic                   pick_valid;
  logic [P_IDX_WIDTH-1:0] sel;
  logic                   sel_valid;
  logic                   slot_free;
  logic                   pop;

  fifo_arb_rr_pick #(
    .P_NUM_REQ  (P_NUM_REQ),
    .P_IDX_WIDTH(P_IDX_WIDTH)
  ) u_pick (
    .req      (~req_empty),
    .rr_ptr   (rr_ptr),
    .sel      (pick_sel),
    .sel_valid(pick_valid)
  );

  // While locked, only the owning FIFO is eligible; if it underflows the
  // arbiter simply stalls rather than letting another requester in.
  always_comb begin
    sel       = pick_sel;
    sel_valid = pick_valid;
    if (state == LOCKED) begin
      sel       = lock_idx;
      sel_valid = !req_empty[lock_idx];
    end
  end

  assign slot_free = !out_valid || out_ready;
  assign pop       = slot_free && sel_valid && !rst;

  always_comb begin
    req_rd_en = '0;
    if (pop) req_rd_en[sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_src   <= '0;
      state     <= IDLE;
      rr_ptr    <= '0;
      lock_idx  <= '0;
    end else begin
      if (pop) begin
        out_valid <= 1'b1;
        out_data  <= req_data[sel];
        out_last  <= req_last[sel];
        out_src   <= sel;
        case (state)
          IDLE: begin
            if (!req_last[sel]) begin
              state    <= LOCKED;
              lock_idx <= sel;
            end else begin
              rr_ptr <= P_IDX_WIDTH'(rr_next(int'(sel), P_NUM_REQ));
            end
          end
          LOCKED: begin
            if (req_last[sel]) begin
              state  <= IDLE;
              rr_ptr <= P_IDX_WIDTH'(rr_next(int'(lock_idx), P_NUM_REQ));
            end
          end
          default: state <= IDLE;
        endcase
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign dbg_state    = state;
  assign dbg_rr_ptr   = rr_ptr;
  assign dbg_lock_idx = lock_idx;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter: a 4-requester instance (a_*) and a
// 3-requester instance (b_*) for the non-power-of-two wrap case. Each FIFO is
// a small FWFT model; words the consumer accepts are compared in order
// against a hand-written expected queue per instance.
module tb_fifo_rr_arbiter;
  import fifo_arb_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- FIFO models (d=0 -> a, d=1 -> b) ----------------
  logic [W:0] mem [2][4][16];
  int         wr_p [2][4];
  int         rd_p [2][4];

  // ---------------- DUT a: 4 requesters ----------------
  logic [3:0]        a_empty, a_last, a_rd_en;
  logic [3:0][W-1:0] a_data;
  logic              a_valid, a_olast, a_ready;
  logic [W-1:0]      a_odata;
  logic [1:0]        a_src, a_rr, a_lock;
  arb_state_e        a_state;

  fifo_rr_arbiter #(.P_NUM_REQ(4), .P_DATA_WIDTH(W)) u_dut_a (
    .clk(clk), .rst(rst),
    .req_empty(a_empty), .req_data(a_data), .req_last(a_last), .req_rd_en(a_rd_en),
    .out_valid(a_valid), .out_data(a_odata), .out_last(a_olast), .out_src(a_src),
    .out_ready(a_ready),
    .dbg_state(a_state), .dbg_rr_ptr(a_rr), .dbg_lock_idx(a_lock)
  );

  // ---------------- DUT b: 3 requesters ----------------
  logic [2:0]        b_empty, b_last, b_rd_en;
  logic [2:0][W-1:0] b_data;
  logic              b_valid, b_olast, b_ready;
  logic [W-1:0]      b_odata;
  logic [1:0]        b_src, b_rr, b_lock;
  arb_state_e        b_state;

  fifo_rr_arbiter #(.P_NUM_REQ(3), .P_DATA_WIDTH(W)) u_dut_b (
    .clk(clk), .rst(rst),
    .req_empty(b_empty), .req_data(b_data), .req_last(b_last), .req_rd_en(b_rd_en),
    .out_valid(b_valid), .out_data(b_odata), .out_last(b_olast), .out_src(b_src),
    .out_ready(b_ready),
    .dbg_state(b_state), .dbg_rr_ptr(b_rr), .dbg_lock_idx(b_lock)
  );

  // ---------------- scoreboard ----------------
  logic [W+2:0] exp_a[$];
  logic [W+2:0] exp_b[$];
  int tests_run    = 0;
  int tests_failed = 0;
  logic [3:0] cap_a;
  logic [2:0] cap_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push(input int d, input int i, input logic last, input logic [W-1:0] data);
    mem[d][i][wr_p[d][i] % 16] = {last, data};
    wr_p[d][i]++;
  endtask

  task automatic expect_word(input int d, input int src, input logic last, input logic [W-1:0] data);
    if (d == 0) exp_a.push_back({src[1:0], last, data});
    else        exp_b.push_back({src[1:0], last, data});
  endtask

  task automatic fifo_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) rd_p[d][i] = wr_p[d][i];
  endtask

  task automatic drive_heads();
    for (int i = 0; i < 4; i++) begin
      a_empty[i] = (rd_p[0][i] == wr_p[0][i]);
      {a_last[i], a_data[i]} = mem[0][i][rd_p[0][i] % 16];
    end
    for (int i = 0; i < 3; i++) begin
      b_empty[i] = (rd_p[1][i] == wr_p[1][i]);
      {b_last[i], b_data[i]} = mem[1][i][rd_p[1][i] % 16];
    end
  endtask

  // One clock: present FIFO heads at the falling edge, capture pop strobes and
  // consumer handshakes before the rising edge, then advance the FIFO models.
  task automatic step();
    logic [W+2:0] e;
    @(negedge clk);
    drive_heads();
    #1;
    cap_a = a_rd_en;
    cap_b = b_rd_en;
    check("a_rd_en_onehot0", 32'($onehot0(cap_a)), 32'd1);
    check("b_rd_en_onehot0", 32'($onehot0(cap_b)), 32'd1);
    if (a_valid === 1'b1 && a_ready === 1'b1) begin
      if (exp_a.size() == 0) check("a_extra_word", 32'({a_src, a_olast, a_odata}), 32'hFFFF_FFFF);
      else begin
        e = exp_a.pop_front();
        check("a_word", 32'({a_src, a_olast, a_odata}), 32'(e));
      end
    end
    if (b_valid === 1'b1 && b_ready === 1'b1) begin
      if (exp_b.size() == 0) check("b_extra_word", 32'({b_src, b_olast, b_odata}), 32'hFFFF_FFFF);
      else begin
        e = exp_b.pop_front();
        check("b_word", 32'({b_src, b_olast, b_odata}), 32'(e));
      end
    end
    @(posedge clk);
    for (int i = 0; i < 4; i++) if (cap_a[i]) rd_p[0][i]++;
    for (int i = 0; i < 3; i++) if (cap_b[i]) rd_p[1][i]++;
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) begin
        wr_p[d][i] = 0;
        rd_p[d][i] = 0;
        for (int k = 0; k < 16; k++) mem[d][i][k] = '0;
      end
    a_ready = 1'b1;
    b_ready = 1'b1;
    drive_heads();

    // Reset, then load one single-word packet per FIFO while still in reset.
    step();
    push(0, 0, 1'b1, 8'h10); push(0, 1, 1'b1, 8'h20);
    push(0, 2, 1'b1, 8'h30); push(0, 3, 1'b1, 8'h40);
    step();
    check("rst_rd_en_low", 32'(cap_a), 32'h0);
    check("rst_out_valid", 32'(a_valid), 32'h0);
    check("rst_out_last", 32'(a_olast), 32'h0);
    check("rst_out_src", 32'(a_src), 32'h0);
    check("rst_state", 32'(a_state), 32'(IDLE));
    check("rst_rr_ptr", 32'(a_rr), 32'h0);
    check("rst_lock_idx", 32'(a_lock), 32'h0);
    check("rst_b_valid", 32'(b_valid), 32'h0);

    // Basic round-robin: 0,1,2,3 back to back, then the stream ends.
    rst = 1'b0;
    expect_word(0, 0, 1'b1, 8'h10); expect_word(0, 1, 1'b1, 8'h20);
    expect_word(0, 2, 1'b1, 8'h30); expect_word(0, 3, 1'b1, 8'h40);
    for (int c = 0; c < 4; c++) begin
      step();
      check("rr_valid_cont", 32'(a_valid), 32'h1);
      check("rr_src", 32'(a_src), 32'(c));
    end
    step();
    check("rr_valid_end", 32'(a_valid), 32'h0);
    check("rr_ptr_wrap", 32'(a_rr), 32'h0);

    // Packet lock: A1..A3 on FIFO1 before B1 on FIFO2.
    push(0, 1, 1'b0, 8'hA1); push(0, 1, 1'b0, 8'hA2); push(0, 1, 1'b1, 8'hA3);
    push(0, 2, 1'b1, 8'hB1);
    expect_word(0, 1, 1'b0, 8'hA1); expect_word(0, 1, 1'b0, 8'hA2);
    expect_word(0, 1, 1'b1, 8'hA3); expect_word(0, 2, 1'b1, 8'hB1);
    step(); check("lock_pop_a1", 32'(cap_a), 32'h2);
    check("lock_state", 32'(a_state), 32'(LOCKED));
    check("lock_idx", 32'(a_lock), 32'h1);
    step(); check("lock_pop_a2", 32'(cap_a), 32'h2);
    step(); check("lock_pop_a3", 32'(cap_a), 32'h2);
    step(); check("lock_pop_b1", 32'(cap_a), 32'h4);
    step(); check("lock_drain", 32'(a_valid), 32'h0);
    check("lock_rr_ptr", 32'(a_rr), 32'h3);

    // Mid-packet underflow: FIFO0 locked and starved while FIFO3 waits.
    push(0, 0, 1'b0, 8'hC1);
    expect_word(0, 0, 1'b0, 8'hC1);
    step(); check("uf_pop_c1", 32'(cap_a), 32'h1);
    push(0, 3, 1'b1, 8'hD1);
    for (int c = 0; c < 5; c++) begin
      step();
      check("uf_stall_rd_en", 32'(cap_a), 32'h0);
      check("uf_stall_valid", 32'(a_valid), 32'h0);
    end
    check("uf_still_locked", 32'(a_state), 32'(LOCKED));
    push(0, 0, 1'b1, 8'hC2);
    expect_word(0, 0, 1'b1, 8'hC2); expect_word(0, 3, 1'b1, 8'hD1);
    step(); check("uf_pop_c2", 32'(cap_a), 32'h1);
    step(); check("uf_pop_d1", 32'(cap_a), 32'h8);
    step(); check("uf_drain", 32'(a_valid), 32'h0);
    check("uf_rr_ptr", 32'(a_rr), 32'h0);

    // Backpressure: hold E1 for three cycles, then resume without loss.
    push(0, 0, 1'b0, 8'hE1); push(0, 0, 1'b1, 8'hE2); push(0, 1, 1'b1, 8'hF1);
    expect_word(0, 0, 1'b0, 8'hE1); expect_word(0, 0, 1'b1, 8'hE2);
    expect_word(0, 1, 1'b1, 8'hF1);
    step(); check("bp_pop_e1", 32'(cap_a), 32'h1);
    a_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("bp_rd_en", 32'(cap_a), 32'h0);
      check("bp_valid", 32'(a_valid), 32'h1);
      check("bp_hold", 32'({a_src, a_olast, a_odata}), 32'({2'd0, 1'b0, 8'hE1}));
      check("bp_rr_ptr", 32'(a_rr), 32'h0);
      check("bp_state", 32'(a_state), 32'(LOCKED));
    end
    a_ready = 1'b1;
    step(); check("bp_pop_e2", 32'(cap_a), 32'h1);
    step(); check("bp_pop_f1", 32'(cap_a), 32'h2);
    step(); check("bp_drain", 32'(a_valid), 32'h0);
    check("bp_rr_ptr_after", 32'(a_rr), 32'h2);

    // Reset mid-packet on FIFO1: word discarded, lock and pointer cleared.
    push(0, 1, 1'b0, 8'h61); push(0, 1, 1'b0, 8'h62);
    step(); check("mrst_pop_g1", 32'(cap_a), 32'h2);
    check("mrst_locked", 32'(a_state), 32'(LOCKED));
    a_ready = 1'b0;
    rst = 1'b1;
    fifo_reset();
    step();
    check("mrst_rd_en", 32'(cap_a), 32'h0);
    check("mrst_valid", 32'(a_valid), 32'h0);
    check("mrst_state", 32'(a_state), 32'(IDLE));
    check("mrst_rr_ptr", 32'(a_rr), 32'h0);
    check("mrst_lock_idx", 32'(a_lock), 32'h0);
    rst = 1'b0;
    a_ready = 1'b1;
    push(0, 3, 1'b1, 8'h73); push(0, 2, 1'b1, 8'h72);
    expect_word(0, 2, 1'b1, 8'h72); expect_word(0, 3, 1'b1, 8'h73);
    step(); check("mrst_first_grant", 32'(cap_a), 32'h4);
    step(); check("mrst_second_grant", 32'(cap_a), 32'h8);
    step(); check("mrst_drain", 32'(a_valid), 32'h0);

    // Wrap/fairness, 3 requesters: move rr_ptr to 2, then expect 2,0,2,0.
    push(1, 1, 1'b1, 8'h51);
    expect_word(1, 1, 1'b1, 8'h51);
    step(); check("wrap_setup_pop", 32'(cap_b), 32'h2);
    step(); check("wrap_rr_ptr2", 32'(b_rr), 32'h2);
    push(1, 2, 1'b1, 8'h61); push(1, 2, 1'b1, 8'h62);
    push(1, 0, 1'b1, 8'h71); push(1, 0, 1'b1, 8'h72);
    expect_word(1, 2, 1'b1, 8'h61); expect_word(1, 0, 1'b1, 8'h71);
    expect_word(1, 2, 1'b1, 8'h62); expect_word(1, 0, 1'b1, 8'h72);
    step(); check("wrap_g1", 32'(cap_b), 32'h4);
    check("wrap_ptr_to0", 32'(b_rr), 32'h0);
    step(); check("wrap_g2", 32'(cap_b), 32'h1);
    step(); check("wrap_g3", 32'(cap_b), 32'h4);
    step(); check("wrap_g4", 32'(cap_b), 32'h1);
    step(); check("wrap_drain", 32'(b_valid), 32'h0);

    check("a_exp_empty", 32'(exp_a.size()), 32'h0);
    check("b_exp_empty", 32'(exp_b.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
